// File: rtl/spi_ram_wrapper.sv
// spi_ram_wrapper: SPI slave bridging 10-bit command words to a 256x8 single-port RAM.
// Ports: clk (system/SPI bit clock), rst (sync active-high), SS_n (slave select, low active),
//        MOSI (serial in, sampled on rising clk), MISO (registered serial out).

module spi_slave (
    input  logic       clk,
    input  logic       rst,
    input  logic       SS_n,
    input  logic       MOSI,
    input  logic       tx_valid,
    input  logic [7:0] dout,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    output logic       MISO
);
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
    state_t     state;
    logic [3:0] bit_cnt;
    logic [2:0] tx_cnt;
    logic [7:0] tx_shift;
    logic       rd_addr_flag;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            tx_cnt       <= 3'd0;
            tx_shift     <= 8'd0;
            rx_data      <= 10'd0;
            rx_valid     <= 1'b0;
            rd_addr_flag <= 1'b0;
            MISO         <= 1'b0;
        end else if (SS_n) begin
            // deselect drops any partial word or in-flight read byte
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            tx_cnt   <= 3'd0;
            rx_valid <= 1'b0;
            MISO     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: state <= CHK_CMD;
                CHK_CMD: begin
                    state   <= !MOSI ? WRITE : rd_addr_flag ? READ_DATA : READ_ADD;
                    bit_cnt <= 4'd0;
                end
                default: if (bit_cnt != 4'd10) begin
                    rx_data  <= {rx_data[8:0], MOSI};
                    bit_cnt  <= bit_cnt + 4'd1;
                    rx_valid <= bit_cnt == 4'd9;
                    if (bit_cnt == 4'd9 && state == READ_ADD) rd_addr_flag <= 1'b1;
                end
            endcase
            // first bit leaves straight from dout; the remaining seven come from tx_shift
            if (state == READ_DATA && tx_valid) begin
                MISO     <= dout[7];
                tx_shift <= {dout[6:0], 1'b0};
                tx_cnt   <= 3'd7;
            end else if (tx_cnt != 3'd0) begin
                MISO     <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
                tx_cnt   <= tx_cnt - 3'd1;
                if (tx_cnt == 3'd1) rd_addr_flag <= 1'b0;
            end else begin
                MISO <= 1'b0;
            end
        end
    end
endmodule

module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);
    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    // array has no reset so contents survive a mid-transaction reset
    always_ff @(posedge clk) begin
        if (!rst && rx_valid && din[9:8] == 2'b01) mem[wr_addr] <= din[7:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= 8'd0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= rx_valid && din[9:8] == 2'b11;
            if (rx_valid && din[9:8] == 2'b00) wr_addr <= din[ADDR_SIZE-1:0];
            if (rx_valid && din[9:8] == 2'b10) rd_addr <= din[ADDR_SIZE-1:0];
            if (rx_valid && din[9:8] == 2'b11) dout <= mem[rd_addr];
        end
    end
endmodule

module spi_ram_wrapper #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO
);
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    spi_slave u_slave (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .tx_valid(tx_valid),
        .dout(dout), .rx_data(rx_data), .rx_valid(rx_valid), .MISO(MISO)
    );
    spi_ram #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) u_ram (
        .clk(clk), .rst(rst), .din(rx_data), .rx_valid(rx_valid),
        .dout(dout), .tx_valid(tx_valid)
    );
endmodule

// File: tb/tb_spi_ram_wrapper.sv
// tb_spi_ram_wrapper: randomized frame-level checking of the SPI RAM bridge against a behavioural model.
module tb_spi_ram_wrapper;
    logic clk = 1'b0;
    logic rst, SS_n, MOSI, MISO;
    spi_ram_wrapper dut (.clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO));
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] mem_m [256];
    logic [7:0] wr_m, rd_m, rx_byte;
    logic       flag_m;
    logic       exp_miso, exp_rxv, chk_en;
    logic [9:0] exp_rxd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        check("miso", 32'(MISO), 32'(exp_miso));
        check("rx_valid", 32'(dut.u_slave.rx_valid), 32'(exp_rxv));
        if (exp_rxv) check("rx_data", 32'(dut.u_slave.rx_data), 32'(exp_rxd));
    end

    // apply inputs, take one rising edge, then publish what outputs must be after that edge
    task automatic drive(input logic ss, input logic mo, input logic em, input logic erv);
        SS_n = ss;
        MOSI = mo;
        @(posedge clk);
        #1;
        exp_miso = em;
        exp_rxv  = erv;
    endtask

    // one frame: select, selector bit, nb word bits (10 = complete), optional abort mid read-out
    task automatic frame(input logic sel, input logic [9:0] w, input int nb, input bit ab_shift);
        int route;
        bit sh;
        logic [7:0] b;
        route = !sel ? 0 : flag_m ? 2 : 1;
        drive(1'b0, 1'($urandom), 1'b0, 1'b0);
        drive(1'b0, sel, 1'b0, 1'b0);
        exp_rxd = w;
        for (int i = 0; i < nb; i++) drive(1'b0, w[9-i], 1'b0, i == 9);
        if (nb == 10) begin
            sh = route == 2 && w[9:8] == 2'b11;
            b = mem_m[rd_m];
            if (w[9:8] == 2'b00) wr_m = w[7:0];
            if (w[9:8] == 2'b01) mem_m[wr_m] = w[7:0];
            if (w[9:8] == 2'b10) rd_m = w[7:0];
            if (route == 1) flag_m = 1'b1;
            rx_byte = 8'd0;
            for (int k = 11; k <= 21; k++) begin
                if (sh && ab_shift && k == 15) break;
                drive(1'b0, 1'($urandom), (sh && k >= 12 && k <= 19) ? b[19-k] : 1'b0, 1'b0);
                if (sh && k >= 12 && k <= 19) rx_byte = {rx_byte[6:0], MISO};
            end
            if (sh && !ab_shift) flag_m = 1'b0;
        end
        repeat (1 + $urandom_range(0, 1)) drive(1'b1, 1'($urandom), 1'b0, 1'b0);
        check("mem_at_wr_addr", 32'(dut.u_ram.mem[wr_m]), 32'(mem_m[wr_m]));
        check("rd_addr_flag", 32'(dut.u_slave.rd_addr_flag), 32'(flag_m));
    endtask

    initial begin
        logic [1:0] op;
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; chk_en = 1'b0;
        exp_miso = 1'b0; exp_rxv = 1'b0; exp_rxd = 10'd0;
        wr_m = 8'd0; rd_m = 8'd0; flag_m = 1'b0; rx_byte = 8'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_miso", 32'(MISO), 0);
        check("rst_rx_valid", 32'(dut.u_slave.rx_valid), 0);
        check("rst_flag", 32'(dut.u_slave.rd_addr_flag), 0);
        check("rst_wr_addr", 32'(dut.u_ram.wr_addr), 0);
        check("rst_tx_valid", 32'(dut.u_ram.tx_valid), 0);
        repeat (3) drive(1'b1, 1'($urandom), 1'b0, 1'b0);

        frame(1'b0, 10'h005, 10, 0);
        check("lit_wr_addr", 32'(dut.u_ram.wr_addr), 32'h05);
        frame(1'b0, 10'h1A3, 10, 0);
        check("lit_mem5", 32'(dut.u_ram.mem[5]), 32'hA3);
        check("lit_model_mem5", 32'(mem_m[5]), 32'hA3);
        frame(1'b1, 10'h205, 10, 0);
        check("lit_flag_set", 32'(dut.u_slave.rd_addr_flag), 1);
        frame(1'b1, 10'h300, 10, 0);
        check("lit_miso_byte", 32'(rx_byte), 32'hA3);
        check("lit_flag_clr", 32'(dut.u_slave.rd_addr_flag), 0);
        frame(1'b0, 10'h1FF, 5, 0);
        check("lit_abort_mem5", 32'(dut.u_ram.mem[5]), 32'hA3);
        frame(1'b0, 10'h00A, 10, 0);
        check("lit_wr_addr_a", 32'(dut.u_ram.wr_addr), 32'h0A);

        // reset in the middle of a word: registers clear, memory keeps its data
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'($urandom), 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        wr_m = 8'd0; rd_m = 8'd0; flag_m = 1'b0;
        check("midrst_wr_addr", 32'(dut.u_ram.wr_addr), 0);
        check("midrst_mem5", 32'(dut.u_ram.mem[5]), 32'hA3);

        for (int a = 0; a < 256; a++) begin
            frame(1'b0, {2'b00, 8'(a)}, 10, 0);
            frame(1'b0, {2'b01, 8'($urandom)}, 10, 0);
        end
        repeat (300) begin
            op = 2'($urandom_range(0, 3));
            frame(($urandom_range(0, 7) == 0) ? ~op[1] : op[1], {op, 8'($urandom)},
                  ($urandom_range(0, 9) == 0) ? $urandom_range(1, 9) : 10, $urandom_range(0, 5) == 0);
        end
        for (int a = 0; a < 256; a++) check("final_mem", 32'(dut.u_ram.mem[a]), 32'(mem_m[a]));
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
